// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format classes, RV32I/RV64I opcodes
// and the entry layout carried through the stage.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT,
        IMM_Z
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int IMM_MAX_XLEN  = 64;
    localparam int IMM_MAX_TAG_W = 64;

    // Widest-configuration entry; the stage keeps a width-exact copy of this layout.
    typedef struct packed {
        logic [IMM_MAX_XLEN-1:0]  imm;
        imm_fmt_e                 fmt;
        logic                     illegal;
        logic [IMM_MAX_TAG_W-1:0] tag;
    } imm_entry_t;

    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational immediate decode: extracts and extends the immediate of a
// 32-bit instruction to XLEN bits and classifies its format.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i_type;
    logic [XLEN-1:0] imm_s_type;
    logic [XLEN-1:0] imm_b_type;
    logic [XLEN-1:0] imm_u_type;
    logic [XLEN-1:0] imm_j_type;
    logic [XLEN-1:0] imm_shamt5;
    logic [XLEN-1:0] imm_shamt_native;
    logic [XLEN-1:0] imm_z_type;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    assign imm_i_type = XLEN'($signed(instr_i[31:20]));
    assign imm_s_type = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b_type = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                       instr_i[11:8], 1'b0}));
    assign imm_u_type = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j_type = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                       instr_i[30:21], 1'b0}));
    assign imm_shamt5 = XLEN'(instr_i[24:20]);
    // RV64 OP-IMM shifts take a 6-bit shamt; the word-sized forms stay at 5 bits.
    assign imm_shamt_native = (XLEN == 64) ? XLEN'(instr_i[25:20]) : imm_shamt5;
    assign imm_z_type = XLEN'(instr_i[19:15]);

    always_comb begin
        imm_o     = '0;
        fmt_o     = IMM_NONE;
        illegal_o = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opcode)
                OPC_OP_IMM: begin
                    if (is_shift_f3(funct3)) begin
                        imm_o = imm_shamt_native;
                        fmt_o = IMM_SHAMT;
                    end else begin
                        imm_o = imm_i_type;
                        fmt_o = IMM_I;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (XLEN != 64) begin
                        illegal_o = 1'b1;
                    end else if (is_shift_f3(funct3)) begin
                        imm_o = imm_shamt5;
                        fmt_o = IMM_SHAMT;
                    end else begin
                        imm_o = imm_i_type;
                        fmt_o = IMM_I;
                    end
                end
                OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                    imm_o = imm_i_type;
                    fmt_o = IMM_I;
                end
                OPC_STORE: begin
                    imm_o = imm_s_type;
                    fmt_o = IMM_S;
                end
                OPC_BRANCH: begin
                    imm_o = imm_b_type;
                    fmt_o = IMM_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm_o = imm_u_type;
                    fmt_o = IMM_U;
                end
                OPC_JAL: begin
                    imm_o = imm_j_type;
                    fmt_o = IMM_J;
                end
                OPC_SYSTEM: begin
                    if (funct3[2]) begin
                        imm_o = imm_z_type;
                        fmt_o = IMM_Z;
                    end
                end
                OPC_OP: begin
                    fmt_o = IMM_NONE;
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a main/skid entry pair so inReady comes
// straight from a flop and backpressure never creates a combinational ready path.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [31:0]      instruction,
    input  logic [TAG_W-1:0] tagIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [XLEN-1:0]  immediateValue,
    output imm_fmt_e         immFormat,
    output logic             immIllegal,
    output logic [TAG_W-1:0] tagOut
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    entry_t          dec_entry;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_xfer;
    logic   out_xfer;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (instruction),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: tagIn};

    assign inReady  = !skid_valid_q;
    assign in_xfer  = inValid && inReady;
    assign out_xfer = main_valid_q && outReady;

    // Skid only fills while main is stalled, so a valid skid always drains into main first.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign outValid       = main_valid_q;
    assign immediateValue = main_q.imm;
    assign immFormat      = main_q.fmt;
    assign immIllegal     = main_q.illegal;
    assign tagOut         = main_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are compared against a two-deep FIFO model with an arithmetic decode reference.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] tag_in;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tag_out32;
    imm_fmt_e    fmt32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag_out64;
    imm_fmt_e    fmt64;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model_q[$];

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .reset(rst), .flush(flush), .inValid(in_valid), .inReady(in_ready32),
        .instruction(instruction), .tagIn(tag_in), .outValid(out_valid32), .outReady(out_ready),
        .immediateValue(imm32), .immFormat(fmt32), .immIllegal(ill32), .tagOut(tag_out32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .reset(rst), .flush(flush), .inValid(in_valid), .inReady(in_ready64),
        .instruction(instruction), .tagIn(tag_in), .outValid(out_valid64), .outReady(out_ready),
        .immediateValue(imm64), .immFormat(fmt64), .immIllegal(ill64), .tagOut(tag_out64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << bits) - 64'd1;
        r = v & m;
        if (r[bits-1]) r = r | ~m;
        return r;
    endfunction

    function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        logic [63:0] u;
        logic [2:0]  f3;
        u   = {32'd0, w};
        f3  = w[14:12];
        imm = 64'd0;
        fmt = IMM_NONE;
        ill = 1'b0;
        if (w[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (w[6:0])
                7'h13, 7'h1B: begin
                    if (w[6:0] == 7'h1B && xlen == 32) begin
                        ill = 1'b1;
                    end else if (f3 == 3'd1 || f3 == 3'd5) begin
                        fmt = IMM_SHAMT;
                        imm = (u >> 20) & ((xlen == 64 && w[6:0] == 7'h13) ? 64'd63 : 64'd31);
                    end else begin
                        fmt = IMM_I;
                        imm = sx(u >> 20, 12);
                    end
                end
                7'h03, 7'h67, 7'h0F: begin
                    fmt = IMM_I;
                    imm = sx(u >> 20, 12);
                end
                7'h23: begin
                    fmt = IMM_S;
                    imm = sx(((u >> 25) << 5) | ((u >> 7) & 64'd31), 12);
                end
                7'h63: begin
                    fmt = IMM_B;
                    imm = sx(((u >> 31) << 12) | (((u >> 7) & 64'd1) << 11)
                             | (((u >> 25) & 64'd63) << 5) | (((u >> 8) & 64'd15) << 1), 13);
                end
                7'h37, 7'h17: begin
                    fmt = IMM_U;
                    imm = sx((u >> 12) << 12, 32);
                end
                7'h6F: begin
                    fmt = IMM_J;
                    imm = sx(((u >> 31) << 20) | (((u >> 12) & 64'd255) << 12)
                             | (((u >> 20) & 64'd1) << 11) | (((u >> 21) & 64'd1023) << 1), 21);
                end
                7'h73: begin
                    if (f3[2]) begin
                        fmt = IMM_Z;
                        imm = (u >> 15) & 64'd31;
                    end
                end
                7'h33: ;
                default: ill = 1'b1;
            endcase
        end
        if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 13))
            0:  w[6:0] = 7'h13;
            1:  w[6:0] = 7'h1B;
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h0F;
            5:  w[6:0] = 7'h23;
            6:  w[6:0] = 7'h63;
            7:  w[6:0] = 7'h37;
            8:  w[6:0] = 7'h17;
            9:  w[6:0] = 7'h6F;
            10: w[6:0] = 7'h73;
            11: w[6:0] = 7'h33;
            default: ;
        endcase
        return w;
    endfunction

    // Two-deep FIFO view of the stage: ready while fewer than two entries are held.
    task automatic model_update();
        logic can_take;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            can_take = (model_q.size() < 2);
            if (model_q.size() > 0 && out_ready) model_q.delete(0);
            if (in_valid && can_take) model_q.push_back({tag_in, instruction});
        end
    endtask

    task automatic check_dut(input string nm, input int xlen, input logic rdy, input logic vld,
                             input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                             input logic [31:0] tg);
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        chk({nm, "_inReady"}, rdy, model_q.size() < 2);
        chk({nm, "_outValid"}, vld, model_q.size() > 0);
        if (model_q.size() > 0) begin
            ref_decode(model_q[0][31:0], xlen, e_imm, e_fmt, e_ill);
            chk({nm, "_imm"}, imm, e_imm);
            chk({nm, "_fmt"}, fmt, e_fmt);
            chk({nm, "_illegal"}, ill, e_ill);
            chk({nm, "_tag"}, tg, model_q[0][63:32]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_dut("m32", 32, in_ready32, out_valid32, imm32, fmt32, ill32, tag_out32);
        check_dut("m64", 64, in_ready64, out_valid64, imm64, fmt64, ill64, tag_out64);
    endtask

    typedef struct packed {
        logic [31:0] w;
        logic [63:0] e32;
        logic [2:0]  f32;
        logic        i32;
        logic [63:0] e64;
        logic [2:0]  f64;
        logic        i64;
    } dir_t;

    localparam int N_DIR = 12;
    localparam dir_t DIR [N_DIR] = '{
        '{32'hFFF00093, 64'hFFFFFFFF, IMM_I,     1'b0, 64'hFFFFFFFFFFFFFFFF, IMM_I,     1'b0},
        '{32'hFE112E23, 64'hFFFFFFFC, IMM_S,     1'b0, 64'hFFFFFFFFFFFFFFFC, IMM_S,     1'b0},
        // beq x0,x0,-4
        '{32'hFE000EE3, 64'hFFFFFFFC, IMM_B,     1'b0, 64'hFFFFFFFFFFFFFFFC, IMM_B,     1'b0},
        '{32'h123450B7, 64'h12345000, IMM_U,     1'b0, 64'h0000000012345000, IMM_U,     1'b0},
        '{32'h8000006F, 64'hFFF00000, IMM_J,     1'b0, 64'hFFFFFFFFFFF00000, IMM_J,     1'b0},
        '{32'h41F0D093, 64'd31,       IMM_SHAMT, 1'b0, 64'd31,               IMM_SHAMT, 1'b0},
        '{32'h3400D073, 64'd1,        IMM_Z,     1'b0, 64'd1,                IMM_Z,     1'b0},
        '{32'h43F0D093, 64'd31,       IMM_SHAMT, 1'b0, 64'd63,               IMM_SHAMT, 1'b0},
        '{32'h00000000, 64'd0,        IMM_NONE,  1'b1, 64'd0,                IMM_NONE,  1'b1},
        '{32'hFFFFFFFF, 64'd0,        IMM_NONE,  1'b1, 64'd0,                IMM_NONE,  1'b1},
        '{32'h0000001B, 64'd0,        IMM_NONE,  1'b1, 64'd0,                IMM_I,     1'b0},
        '{32'h00000033, 64'd0,        IMM_NONE,  1'b0, 64'd0,                IMM_NONE,  1'b0}
    };

    task automatic expect_out(input int k);
        dir_t d;
        d = DIR[k];
        chk($sformatf("dir%0d_v32", k), out_valid32, 1'b1);
        chk($sformatf("dir%0d_imm32", k), imm32, d.e32);
        chk($sformatf("dir%0d_fmt32", k), fmt32, d.f32);
        chk($sformatf("dir%0d_ill32", k), ill32, d.i32);
        chk($sformatf("dir%0d_v64", k), out_valid64, 1'b1);
        chk($sformatf("dir%0d_imm64", k), imm64, d.e64);
        chk($sformatf("dir%0d_fmt64", k), fmt64, d.f64);
        chk($sformatf("dir%0d_ill64", k), ill64, d.i64);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_outValid32"}, out_valid32, 1'b0);
        chk({nm, "_inReady32"}, in_ready32, 1'b1);
        chk({nm, "_imm32"}, imm32, 32'd0);
        chk({nm, "_fmt32"}, fmt32, IMM_NONE);
        chk({nm, "_ill32"}, ill32, 1'b0);
        chk({nm, "_tag32"}, tag_out32, 32'd0);
        chk({nm, "_outValid64"}, out_valid64, 1'b0);
        chk({nm, "_inReady64"}, in_ready64, 1'b1);
        chk({nm, "_imm64"}, imm64, 64'd0);
        chk({nm, "_tag64"}, tag_out64, 32'd0);
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instruction = 32'd0;
        tag_in      = 32'd0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed stream, one instruction per cycle with outReady high.
        for (int i = 0; i < N_DIR; i++) begin
            in_valid    = 1'b1;
            instruction = DIR[i].w;
            tag_in      = 32'h1000 + 32'(i * 4);
            step();
            expect_out(i);
            chk("dir_tag", tag_out32, 32'h1000 + 32'(i * 4));
        end
        in_valid = 1'b0;
        step();
        chk("dir_drained", out_valid32, 1'b0);

        // Backpressure: A held in main, B parked in skid.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'hFFF00093;
        tag_in      = 32'hA;
        step();
        instruction = 32'h123450B7;
        tag_in      = 32'hB;
        step();
        in_valid = 1'b0;
        step();
        chk("bp_inReady_low", in_ready32, 1'b0);
        chk("bp_held_imm", imm32, 32'hFFFFFFFF);
        chk("bp_held_tag", tag_out32, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_second_imm", imm32, 32'h12345000);
        chk("bp_second_tag", tag_out32, 32'hB);
        chk("bp_inReady_back", in_ready32, 1'b1);
        step();
        chk("bp_empty", out_valid32, 1'b0);

        // Flush with both entries full and an input presented.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'hFFF00093;
        step();
        instruction = 32'hFE112E23;
        step();
        instruction = 32'h8000006F;
        flush       = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_outValid", out_valid32, 1'b0);
        chk("flush_inReady", in_ready32, 1'b1);
        chk("flush_outValid64", out_valid64, 1'b0);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h3400D073;
        step();
        chk("flush_next_imm", imm32, 32'd1);
        chk("flush_next_fmt", fmt32, IMM_Z);
        in_valid = 1'b0;
        step();
        chk("flush_empty", out_valid32, 1'b0);

        // Asynchronous reset in the middle of a stalled stream.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'hFE000EE3;
        tag_in      = 32'h55;
        step();
        instruction = 32'h8000006F;
        step();
        #2 rst = 1'b1;
        model_q.delete();
        #1 check_reset_state("midrst");
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h123450B7;
        tag_in      = 32'h77;
        step();
        chk("postrst_imm", imm32, 32'h12345000);
        chk("postrst_tag", tag_out32, 32'h77);
        in_valid = 1'b0;
        step();

        // Randomized traffic with backpressure and occasional flushes.
        for (int c = 0; c < 600; c++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 39) == 0);
            instruction = rand_instr();
            tag_in      = $urandom();
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("final_empty", out_valid32, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
